alu_ctrl_seq: RTL and testbench

// - Registered, handshaked ALU control for the pipelined core. Sits between ID/EX and the execute stage.
// - Decodes funct/ALUOp into ALU operation and functional-unit result select, as the single-cycle ALU control does.
// - Adds a multiply/divide (MDU) op class. Sequences the iterative MDU with a cycle counter and stalls upstream until the MDU result is ready.

---
 rtl/alu_ctrl_pkg.sv | 58 +++++
 rtl/alu_ctrl_dec.sv | 53 +++++
 rtl/alu_ctrl_seq.sv | 157 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// alu_ctrl_pkg : shared ALU-control encodings, decode record and FSM states
// Revision     : 1.0
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

   // ALUOp op classes
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_LUI   = 3'b011;
   localparam logic [2:0] ALUOP_MDU   = 3'b100;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRAV = 4'b1001;
   localparam logic [3:0] ALU_SLL  = 4'b1000;

   // Functional-unit result select
   localparam logic [1:0] FUR_ALU   = 2'b00;
   localparam logic [1:0] FUR_SHIFT = 2'b01;
   localparam logic [1:0] FUR_ZERO  = 2'b10;
   localparam logic [1:0] FUR_MDU   = 2'b11;

   // MDU operations
   localparam logic [1:0] MDU_MUL  = 2'b00;
   localparam logic [1:0] MDU_MULU = 2'b01;
   localparam logic [1:0] MDU_DIV  = 2'b10;
   localparam logic [1:0] MDU_DIVU = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [1:0] furslt;
      logic       illegal;
      logic       is_mdu;
      logic [1:0] mdu_op;
   } dec_t;

   function automatic logic mdu_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
// ============================================================================
// alu_ctrl_dec : combinational funct/ALUOp decode into ALU op, result select
// Revision     : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_dec
   import alu_ctrl_pkg::*;
(
   input  logic [2:0] funct_i,
   input  logic [2:0] aluop_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o        = '0;
      dec_o.mdu_op = funct_i[1:0];
      case (aluop_i)
         ALUOP_ADD: dec_o.alu_op = ALU_ADD;
         ALUOP_SUB: dec_o.alu_op = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct_i)
               3'b000: dec_o.alu_op = ALU_ADD;
               3'b001: dec_o.alu_op = ALU_SUB;
               3'b010: dec_o.alu_op = ALU_AND;
               3'b011: dec_o.alu_op = ALU_OR;
               3'b100: dec_o.alu_op = ALU_NOR;
               3'b101: dec_o.alu_op = ALU_SLT;
               3'b110: dec_o.alu_op = ALU_SRAV;
               default: dec_o.alu_op = ALU_SLL;
            endcase
            // Shift ops route through the shifter rather than the ALU
            dec_o.furslt = (funct_i[2:1] == 2'b11) ? FUR_SHIFT : FUR_ALU;
         end
         ALUOP_LUI: begin
            dec_o.alu_op = ALU_SLL;
            dec_o.furslt = FUR_ZERO;
         end
         ALUOP_MDU: begin
            dec_o.alu_op = ALU_SLL;
            dec_o.furslt = FUR_MDU;
            dec_o.is_mdu = 1'b1;
         end
         default: begin
            dec_o.alu_op  = ALU_SLL;
            dec_o.illegal = 1'b1;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
// ============================================================================
// alu_ctrl_seq : registered, handshaked ALU control with iterative MDU sequencing
// Revision     : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int FUNCT_W    = 6,
   parameter int MUL_CYCLES = 32,
   parameter int DIV_CYCLES = 34
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [2:0]         ALUOp_i,
   input  logic               flush_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [3:0]         ALU_operation_o,
   output logic [1:0]         FURslt_o,
   output logic               illegal_o,
   output logic               mdu_start_o,
   output logic [1:0]         mdu_op_o,
   output logic               mdu_abort_o
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic             valid_q,     valid_d;
   logic [3:0]       alu_op_q,    alu_op_d;
   logic [1:0]       furslt_q,    furslt_d;
   logic             illegal_q,   illegal_d;
   logic [1:0]       mdu_op_q,    mdu_op_d;
   logic             mdu_start_q, mdu_start_d;
   logic             mdu_abort_q, mdu_abort_d;

   dec_t dec;
   logic accept;
   logic unused_funct_hi;

   // Only the low funct bits carry meaning for this decoder
   assign unused_funct_hi = ^funct_i[FUNCT_W-1:3];

   alu_ctrl_dec u_dec (
      .funct_i (funct_i[2:0]),
      .aluop_i (ALUOp_i),
      .dec_o   (dec)
   );

   assign ready_o = (state_q == ST_IDLE) && (!valid_q || ready_i);
   assign accept  = valid_i && ready_o && !flush_i;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      valid_d     = valid_q;
      alu_op_d    = alu_op_q;
      furslt_d    = furslt_q;
      illegal_d   = illegal_q;
      mdu_op_d    = mdu_op_q;
      mdu_start_d = 1'b0;
      mdu_abort_d = 1'b0;

      if (flush_i) begin
         state_d     = ST_IDLE;
         count_d     = '0;
         valid_d     = 1'b0;
         mdu_abort_d = (state_q != ST_IDLE) || mdu_start_q;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  alu_op_d  = dec.alu_op;
                  furslt_d  = dec.furslt;
                  illegal_d = dec.illegal;
                  if (dec.is_mdu) begin
                     state_d     = ST_BUSY;
                     valid_d     = 1'b0;
                     mdu_start_d = 1'b1;
                     mdu_op_d    = dec.mdu_op;
                     count_d     = mdu_is_div(dec.mdu_op) ? DIV_LOAD : MUL_LOAD;
                  end else begin
                     valid_d = 1'b1;
                  end
               end else if (ready_i) begin
                  valid_d = 1'b0;
               end
            end
            ST_BUSY: begin
               valid_d = 1'b0;
               // Count reaches zero on the last busy cycle; result shows next cycle
               if (count_q == '0) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
            ST_DONE: begin
               if (ready_i) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               count_d = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         valid_q     <= 1'b0;
         alu_op_q    <= '0;
         furslt_q    <= '0;
         illegal_q   <= 1'b0;
         mdu_op_q    <= '0;
         mdu_start_q <= 1'b0;
         mdu_abort_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         alu_op_q    <= alu_op_d;
         furslt_q    <= furslt_d;
         illegal_q   <= illegal_d;
         mdu_op_q    <= mdu_op_d;
         mdu_start_q <= mdu_start_d;
         mdu_abort_q <= mdu_abort_d;
      end
   end

   assign valid_o         = valid_q;
   assign ALU_operation_o = alu_op_q;
   assign FURslt_o        = furslt_q;
   assign illegal_o       = illegal_q && valid_q;
   assign mdu_start_o     = mdu_start_q;
   assign mdu_op_o        = mdu_op_q;
   assign mdu_abort_o     = mdu_abort_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
// ============================================================================
// tb_alu_ctrl_seq : directed self-checking bench for alu_ctrl_seq
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl_seq;

   localparam int MUL_C = 4;
   localparam int DIV_C = 6;

   logic       clk_i   = 1'b0;
   logic       rst_i   = 1'b1;
   logic       valid_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       ready_i = 1'b0;
   logic [5:0] funct_i = '0;
   logic [2:0] ALUOp_i = '0;

   logic       ready_o;
   logic       valid_o;
   logic [3:0] ALU_operation_o;
   logic [1:0] FURslt_o;
   logic       illegal_o;
   logic       mdu_start_o;
   logic [1:0] mdu_op_o;
   logic       mdu_abort_o;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk_i = ~clk_i;

   alu_ctrl_seq #(
      .FUNCT_W    (6),
      .MUL_CYCLES (MUL_C),
      .DIV_CYCLES (DIV_C)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .funct_i         (funct_i),
      .ALUOp_i         (ALUOp_i),
      .flush_i         (flush_i),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .ALU_operation_o (ALU_operation_o),
      .FURslt_o        (FURslt_o),
      .illegal_o       (illegal_o),
      .mdu_start_o     (mdu_start_o),
      .mdu_op_o        (mdu_op_o),
      .mdu_abort_o     (mdu_abort_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                        input logic rdy, input logic fl);
      valid_i = v;
      ALUOp_i = op;
      funct_i = f;
      ready_i = rdy;
      flush_i = fl;
      #1;
   endtask

   task automatic mdu_run(input string tag, input logic [5:0] f, input int cycles);
      drive(1'b1, 3'b100, f, 1'b1, 1'b0);
      check({tag, "_acc_ready"}, 32'(ready_o), 1);
      tick();
      drive(1'b0, 3'b100, f, 1'b1, 1'b0);
      check({tag, "_start"}, 32'(mdu_start_o), 1);
      check({tag, "_start_valid"}, 32'(valid_o), 0);
      check({tag, "_start_ready"}, 32'(ready_o), 0);
      check({tag, "_op"}, 32'(mdu_op_o), 32'(f[1:0]));
      for (int i = 1; i < cycles; i++) begin
         tick();
         check({tag, "_busy_start"}, 32'(mdu_start_o), 0);
         check({tag, "_busy_valid"}, 32'(valid_o), 0);
         check({tag, "_busy_ready"}, 32'(ready_o), 0);
         check({tag, "_busy_op"}, 32'(mdu_op_o), 32'(f[1:0]));
      end
      tick();
      check({tag, "_done_valid"}, 32'(valid_o), 1);
      check({tag, "_done_fur"}, 32'(FURslt_o), 'b11);
      check({tag, "_done_alu"}, 32'(ALU_operation_o), 'b1000);
      check({tag, "_done_ready"}, 32'(ready_o), 0);
      check({tag, "_done_illegal"}, 32'(illegal_o), 0);
      tick();
      check({tag, "_ret_valid"}, 32'(valid_o), 0);
      check({tag, "_ret_ready"}, 32'(ready_o), 1);
   endtask

   initial begin
      logic seen_valid;

      repeat (2) tick();
      check("rst_valid", 32'(valid_o), 0);
      check("rst_alu", 32'(ALU_operation_o), 0);
      check("rst_fur", 32'(FURslt_o), 0);
      check("rst_illegal", 32'(illegal_o), 0);
      check("rst_start", 32'(mdu_start_o), 0);
      check("rst_abort", 32'(mdu_abort_o), 0);
      check("rst_ready", 32'(ready_o), 1);
      rst_i = 1'b0;

      // Single R-type SUB, then a back-to-back stream
      drive(1'b1, 3'b010, 6'b000001, 1'b1, 1'b0);
      check("sub_acc_ready", 32'(ready_o), 1);
      tick();
      check("sub_valid", 32'(valid_o), 1);
      check("sub_alu", 32'(ALU_operation_o), 'b0110);
      check("sub_fur", 32'(FURslt_o), 'b00);
      drive(1'b1, 3'b000, 6'b000000, 1'b1, 1'b0);
      tick();
      check("add_valid", 32'(valid_o), 1);
      check("add_alu", 32'(ALU_operation_o), 'b0010);
      check("add_fur", 32'(FURslt_o), 'b00);
      drive(1'b1, 3'b010, 6'b000100, 1'b1, 1'b0);
      tick();
      check("nor_valid", 32'(valid_o), 1);
      check("nor_alu", 32'(ALU_operation_o), 'b1100);
      check("nor_fur", 32'(FURslt_o), 'b00);
      drive(1'b1, 3'b010, 6'b000110, 1'b1, 1'b0);
      tick();
      check("srav_valid", 32'(valid_o), 1);
      check("srav_alu", 32'(ALU_operation_o), 'b1001);
      check("srav_fur", 32'(FURslt_o), 'b01);

      // Downstream stall with a pending AND upstream
      drive(1'b1, 3'b010, 6'b000010, 1'b0, 1'b0);
      check("stall_ready0", 32'(ready_o), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", 32'(valid_o), 1);
         check("stall_alu", 32'(ALU_operation_o), 'b1001);
         check("stall_fur", 32'(FURslt_o), 'b01);
         check("stall_ready", 32'(ready_o), 0);
      end
      drive(1'b1, 3'b010, 6'b000010, 1'b1, 1'b0);
      check("resume_ready", 32'(ready_o), 1);
      tick();
      check("and_valid", 32'(valid_o), 1);
      check("and_alu", 32'(ALU_operation_o), 'b0000);
      drive(1'b0, 3'b000, 6'b000000, 1'b0, 1'b0);
      tick();
      check("hold_valid", 32'(valid_o), 1);
      check("hold_alu", 32'(ALU_operation_o), 'b0000);
      drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);
      tick();
      check("drain_valid", 32'(valid_o), 0);
      check("drain_ready", 32'(ready_o), 1);

      mdu_run("mul", 6'b000000, MUL_C);
      mdu_run("div", 6'b000010, DIV_C);

      // Flush two cycles into a divu, with a coincident valid_i
      drive(1'b1, 3'b100, 6'b000011, 1'b1, 1'b0);
      tick();
      drive(1'b0, 3'b100, 6'b000011, 1'b1, 1'b0);
      check("fl_start", 32'(mdu_start_o), 1);
      tick();
      tick();
      drive(1'b1, 3'b000, 6'b000000, 1'b1, 1'b1);
      tick();
      drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);
      check("fl_abort", 32'(mdu_abort_o), 1);
      check("fl_valid", 32'(valid_o), 0);
      check("fl_ready", 32'(ready_o), 1);
      tick();
      check("fl_abort_once", 32'(mdu_abort_o), 0);
      seen_valid = 1'b0;
      for (int i = 0; i < DIV_C + 2; i++) begin
         tick();
         if (valid_o) seen_valid = 1'b1;
      end
      check("fl_no_late_valid", 32'(seen_valid), 0);

      // Flush in IDLE drops the coincident op, no abort
      drive(1'b1, 3'b000, 6'b000000, 1'b1, 1'b1);
      tick();
      drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);
      check("fli_valid", 32'(valid_o), 0);
      check("fli_abort", 32'(mdu_abort_o), 0);

      // Flush on the start-pulse cycle
      drive(1'b1, 3'b100, 6'b000000, 1'b1, 1'b0);
      tick();
      drive(1'b0, 3'b100, 6'b000000, 1'b1, 1'b1);
      check("fls_start", 32'(mdu_start_o), 1);
      tick();
      drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);
      check("fls_abort", 32'(mdu_abort_o), 1);
      check("fls_valid", 32'(valid_o), 0);
      check("fls_start_gone", 32'(mdu_start_o), 0);

      // Reserved and LUI classes
      drive(1'b1, 3'b101, 6'b000000, 1'b1, 1'b0);
      tick();
      check("ill_valid", 32'(valid_o), 1);
      check("ill_flag", 32'(illegal_o), 1);
      check("ill_alu", 32'(ALU_operation_o), 'b1000);
      check("ill_fur", 32'(FURslt_o), 'b00);
      drive(1'b1, 3'b011, 6'b000000, 1'b1, 1'b0);
      tick();
      check("lui_flag", 32'(illegal_o), 0);
      check("lui_alu", 32'(ALU_operation_o), 'b1000);
      check("lui_fur", 32'(FURslt_o), 'b10);
      drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);
      tick();

      // Asynchronous reset mid-BUSY
      drive(1'b1, 3'b100, 6'b000010, 1'b1, 1'b0);
      tick();
      drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);
      tick();
      tick();
      rst_i = 1'b1;
      #1;
      check("arst_valid", 32'(valid_o), 0);
      check("arst_start", 32'(mdu_start_o), 0);
      check("arst_abort", 32'(mdu_abort_o), 0);
      check("arst_alu", 32'(ALU_operation_o), 0);
      check("arst_fur", 32'(FURslt_o), 0);
      check("arst_op", 32'(mdu_op_o), 0);
      check("arst_ready", 32'(ready_o), 1);
      tick();
      rst_i = 1'b0;
      tick();
      check("arst_no_abort", 32'(mdu_abort_o), 0);
      check("arst_idle_valid", 32'(valid_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
